// File: rtl/alu_seq_ctrl.sv
// Multicycle control sequencer for the 16-bit bus processor (R0..R7, A, G, ALU).
// Define ALU_SEQ_ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky Error flag.
module alu_seq_ctrl #(
    parameter logic [2:0] ALU_ADD    = 3'b000,
    parameter logic [2:0] ALU_SUB    = 3'b001,
    parameter logic [2:0] ALU_NAND   = 3'b010,
    parameter logic [2:0] ALU_PASS_A = 3'b100
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Run,
    input  logic [15:0] DIN,
    output logic        IRin,
    output logic [7:0]  Rout,
    output logic [7:0]  Rin,
    output logic        DINout,
    output logic        Gout,
    output logic        Ain,
    output logic        Gin,
    output logic [2:0]  OpSelect,
    output logic        Done,
    output logic        Busy,
    output logic        Error
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;

    logic [1:0] step_q, step_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opcode, x_sel, y_sel;
    logic       is_alu_op;
    logic       trap;

    logic       irin_c, dinout_c, gout_c, ain_c, gin_c, done_c;
    logic [7:0] rout_c, rin_c;
    logic [2:0] opsel_c;

    // Only the low nine bits of DIN carry the instruction.
    logic unused_din_hi;
    assign unused_din_hi = ^DIN[15:9];

    function automatic logic [7:0] one_hot(input logic [2:0] idx);
        one_hot = 8'b0000_0001 << idx;
    endfunction

    assign opcode    = ir_q[8:6];
    assign x_sel     = ir_q[5:3];
    assign y_sel     = ir_q[2:0];
    assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_NAND);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ir_d     = ir_q;
        irin_c   = 1'b0;
        rout_c   = '0;
        rin_c    = '0;
        dinout_c = 1'b0;
        gout_c   = 1'b0;
        ain_c    = 1'b0;
        gin_c    = 1'b0;
        opsel_c  = ALU_PASS_A;
        done_c   = 1'b0;
        trap     = 1'b0;

        case (step_q)
            T0: begin
                irin_c = Run;
                if (Run) begin
                    ir_d = DIN[8:0];
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        rout_c = one_hot(y_sel);
                        rin_c  = one_hot(x_sel);
                        done_c = 1'b1;
                    end
                    OP_MVI: begin
                        dinout_c = 1'b1;
                        rin_c    = one_hot(x_sel);
                        done_c   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_NAND: begin
                        rout_c = one_hot(x_sel);
                        ain_c  = 1'b1;
                    end
                    default: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                        trap   = 1'b1;
`else
                        done_c = 1'b1;
`endif
                    end
                endcase
            end
            T2: begin
                if (is_alu_op) begin
                    rout_c = one_hot(y_sel);
                    gin_c  = 1'b1;
                    case (opcode)
                        OP_ADD:  opsel_c = ALU_ADD;
                        OP_SUB:  opsel_c = ALU_SUB;
                        default: opsel_c = ALU_NAND;
                    endcase
                end
            end
            default: begin
                if (is_alu_op) begin
                    gout_c = 1'b1;
                    rin_c  = one_hot(x_sel);
                    done_c = 1'b1;
                end
            end
        endcase
    end

    // T0 waits for Run; any finishing or trapping step falls back to T0.
    always_comb begin
        if (step_q == T0) begin
            step_d = Run ? T1 : T0;
        end else if (done_c || trap) begin
            step_d = T0;
        end else begin
            step_d = step_q + 2'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= T0;
            // NOTE: IR is reset too, so decode never sees X after reset release.
            ir_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic error_q, error_d;

    assign error_d = error_q | trap;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign Error = error_q;
`else
    assign Error = 1'b0;
`endif

    // Outputs are forced idle while reset is held, even if Run is high.
    assign IRin     = Resetn & irin_c;
    assign Rout     = Resetn ? rout_c : 8'h00;
    assign Rin      = Resetn ? rin_c : 8'h00;
    assign DINout   = Resetn & dinout_c;
    assign Gout     = Resetn & gout_c;
    assign Ain      = Resetn & ain_c;
    assign Gin      = Resetn & gin_c;
    assign OpSelect = Resetn ? opsel_c : ALU_PASS_A;
    assign Done     = Resetn & done_c;
    assign Busy     = Resetn & (step_q != T0);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl; honours ALU_SEQ_ILLEGAL_TRAP_EN.
module tb_alu_seq_ctrl;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic [15:0] DIN;
    logic        IRin;
    logic [7:0]  Rout;
    logic [7:0]  Rin;
    logic        DINout;
    logic        Gout;
    logic        Ain;
    logic        Gin;
    logic [2:0]  OpSelect;
    logic        Done;
    logic        Busy;
    logic        Error;

    int total = 0;
    int bad   = 0;

    alu_seq_ctrl dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Run      (Run),
        .DIN      (DIN),
        .IRin     (IRin),
        .Rout     (Rout),
        .Rin      (Rin),
        .DINout   (DINout),
        .Gout     (Gout),
        .Ain      (Ain),
        .Gin      (Gin),
        .OpSelect (OpSelect),
        .Done     (Done),
        .Busy     (Busy),
        .Error    (Error)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Compares all control outputs as one vector:
    // {IRin, Rout, Rin, DINout, Gout, Ain, Gin, OpSelect, Done, Busy}
    task automatic expect_outs(input string tag, input logic irin, input logic [7:0] rout,
                               input logic [7:0] rin, input logic dinout, input logic gout,
                               input logic ain, input logic gin, input logic [2:0] opsel,
                               input logic done, input logic busy);
        logic [25:0] obs;
        logic [25:0] exp;
        obs = {IRin, Rout, Rin, DINout, Gout, Ain, Gin, OpSelect, Done, Busy};
        exp = {irin, rout, rin, dinout, gout, ain, gin, opsel, done, busy};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_idle(input string tag);
        expect_outs(tag, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
    endtask

    task automatic expect_error(input string tag, input logic exp);
        total++;
        assert (Error === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, Error, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic trap_en;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        Resetn = 1'b0;
        Run    = 1'b1;
        DIN    = 16'h0050;
        #3;
        expect_idle("in_reset_run_high");
        expect_error("in_reset_error", 1'b0);
        Run = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            next_cycle();
            #1;
            expect_idle("idle_after_reset");
        end

        // mvi R2,#0x1234
        next_cycle(); Run = 1'b1; DIN = 16'h0050; #1;
        expect_outs("mvi_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
        next_cycle(); Run = 1'b0; DIN = 16'h1234; #1;
        expect_outs("mvi_t1", 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1);
        next_cycle(); DIN = 16'h0000; #1;
        expect_idle("mvi_back_t0");

        // add R1,R2
        next_cycle(); Run = 1'b1; DIN = 16'h008A; #1;
        expect_outs("add_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
        next_cycle(); Run = 1'b0; #1;
        expect_outs("add_t1", 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1);
        next_cycle(); #1;
        expect_outs("add_t2", 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1);
        next_cycle(); #1;
        expect_outs("add_t3", 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1);
        next_cycle(); #1;
        expect_idle("add_back_t0");

        // sub R1,R2
        next_cycle(); Run = 1'b1; DIN = 16'h00CA; #1;
        expect_outs("sub_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
        next_cycle(); Run = 1'b0; #1;
        expect_outs("sub_t1", 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1);
        next_cycle(); #1;
        expect_outs("sub_t2", 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b1);
        next_cycle(); #1;
        expect_outs("sub_t3", 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1);

        // mv R0,R3 followed back-to-back by mvi R2 (Run held across Done)
        next_cycle(); Run = 1'b1; DIN = 16'h0003; #1;
        expect_outs("mv_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
        next_cycle(); DIN = 16'h0050; #1;
        expect_outs("mv_t1", 1'b0, 8'h08, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1);
        next_cycle(); #1;
        expect_outs("b2b_mvi_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
        next_cycle(); Run = 1'b0; DIN = 16'hBEEF; #1;
        expect_outs("b2b_mvi_t1", 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1);

        // nand R0,R0 with Run pulsed while busy (DIN would decode as mv R0,R3)
        next_cycle(); Run = 1'b1; DIN = 16'h0100; #1;
        expect_outs("nand_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
        next_cycle(); Run = 1'b1; DIN = 16'h0003; #1;
        expect_outs("nand_t1_run", 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1);
        next_cycle(); #1;
        expect_outs("nand_t2_run", 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1);
        next_cycle(); Run = 1'b0; #1;
        expect_outs("nand_t3", 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1);
        next_cycle(); #1;
        expect_idle("nand_back_t0");

        // add R1,R2 aborted by reset in T2
        next_cycle(); Run = 1'b1; DIN = 16'h008A; #1;
        next_cycle(); Run = 1'b0; #1;
        next_cycle(); #1;
        expect_outs("abort_t2", 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1);
        Resetn = 1'b0;
        #1;
        expect_idle("abort_in_reset");
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            expect_idle("abort_after_release");
        end

        // Illegal opcode 111
        next_cycle(); Run = 1'b1; DIN = 16'h01C0; #1;
        expect_outs("ill_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
        next_cycle(); Run = 1'b0; #1;
        expect_outs("ill_t1", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, !trap_en, 1'b1);
        expect_error("ill_t1_error", 1'b0);
        next_cycle(); #1;
        expect_idle("ill_back_t0");
        expect_error("ill_after_error", trap_en);

        // Error stays set across a legal instruction, clears on reset
        next_cycle(); Run = 1'b1; DIN = 16'h0050; #1;
        next_cycle(); Run = 1'b0; #1;
        expect_outs("post_ill_mvi_t1", 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1);
        next_cycle(); #1;
        expect_error("error_sticky", trap_en);
        Resetn = 1'b0;
        #1;
        expect_error("error_cleared_by_reset", 1'b0);
        @(negedge Clock);
        Resetn = 1'b1;
        next_cycle(); #1;
        expect_idle("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
